decode_queue: RTL
=================

Name: decode_queue

Overview:
- Parametrised instruction buffer and pre-decode stage between IF and ID of the MIPS pipeline.
- Holds up to 2^PTR_W fetched instructions in a circular FIFO with valid/ready handshakes on both sides.
- Classifies the head entry for branch/jump, ERET, SYSCALL, BREAK and reserved-instruction handling.
- Tracks branch-delay-slot (BD) status across pops, and raises a prioritised exception code per instruction.

Parameters:
- PTR_W, 2, pointer width; queue depth DEPTH = 2^PTR_W (legal PTR_W 1..5).
- PC_W, 32, width of the stored PC.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (exception/eret redirect).
- if_valid  input  1  IF presents an instruction.
- if_ready  output  1  queue can accept (count < DEPTH).
- if_pc  input  PC_W  PC of the presented instruction.
- if_inst  input  32  instruction word.
- if_fetch_err  input  1  fetch address error (AdEL) for this instruction.
- id_valid  output  1  head entry is valid.
- id_ready  input  1  ID consumes the head.
- id_pc  output  PC_W  head PC.
- id_inst  output  32  head instruction word.
- id_bd  output  1  head is in a branch delay slot.
- id_is_branch  output  1  head is a branch or jump.
- id_is_eret  output  1  head is ERET (exact word 0x42000018).
- id_exc  output  1  head carries an exception.
- id_excode  output  5  ExcCode; 0 when id_exc=0.
- occupancy  output  PTR_W+1  number of valid entries.

Behaviour:
- Reset (asynchronous): rd_ptr=0, wr_ptr=0, count=0, bd_flag=0, stall_flag=0.
  - All outputs read 0; if_ready=1.
  - Storage RAM is not reset.
- Push when if_valid & if_ready: write {pc, inst, fetch_err} at wr_ptr; wr_ptr += 1, wrapping modulo DEPTH.
- Pop when id_valid & id_ready: rd_ptr += 1, wrapping modulo DEPTH.
- count updates as +1 on push only, -1 on pop only, and is unchanged when both or neither occur.
- Latency: an entry pushed at edge N appears at the id_* outputs after edge N (one cycle, no combinational pass-through).
- if_ready = (count != DEPTH).
  - When full, a same-cycle pop does not raise if_ready; the push waits one cycle.
- id_valid = (count != 0) & !stall_flag. id_pc and id_inst come from the head entry.
- When id_valid=0, the id_* classification outputs are 0; id_pc and id_inst are don't-care.
- Branch class (id_is_branch):
  - opcodes 000010, 000011, 000100, 000101, 000110, 000111;
  - opcode 000001 with rt in {00000, 00001, 10000, 10001};
  - opcode 000000 with funct 001000 or 001001.
- Valid opcodes:
  - 000000–000111;
  - 001000–001111;
  - 010000;
  - 100000–100110;
  - 101000–101011;
  - 101110.
  - Any other opcode is a reserved instruction (RI).
- Exception priority, highest first; excode is the first that applies:
  - fetch_err: AdEL, 4;
  - RI: 10;
  - SYSCALL (opcode 0, funct 001100): 8;
  - BREAK (opcode 0, funct 001101): 9.
- BD tracking:
  - id_bd = bd_flag.
  - On each pop, bd_flag <= id_is_branch of the popped entry, so the instruction following a branch sees id_bd=1.
  - bd_flag is held while no pop occurs.
- flush:
  - count, rd_ptr, wr_ptr, bd_flag and stall_flag all go to 0 at the edge.
  - flush has priority over a same-cycle push or pop; a push in the flush cycle is discarded.
  - id_valid=0 in the following cycle.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro DECODE_QUEUE_STALL_ON_EXC_EN.
- Defined:
  - Popping an entry with id_exc=1 sets stall_flag.
  - While stall_flag=1, id_valid=0 and no pops occur; pushes continue up to full.
  - Only flush or rst clears stall_flag.
- Undefined: stall_flag is held at 0 and entries after an excepting one are presented normally.

Test Plan:
- Reset, then push 0x24010005 (addiu) at PC 0xBFC00000 -> id_valid=1 next cycle, id_exc=0, id_bd=0, occupancy=1.
- PTR_W=2; push 5 back-to-back with id_ready=0 -> if_ready drops after the 4th push, occupancy=4; the 5th is held until a pop and enters one cycle later.
- Push beq 0x10220003, then nop 0x00000000; pop both -> beq shows id_is_branch=1, id_bd=0; nop shows id_bd=1; a following addiu shows id_bd=0.
- Push opcode 0x3F (0xFC000000) with if_fetch_err=1 -> id_excode=4. Same word with fetch_err=0 -> id_excode=10. Push 0x0000000C -> id_excode=8. Push 0x0000000D -> id_excode=9.
- Occupancy 3 with flush and if_valid asserted together -> next cycle occupancy=0, id_valid=0, id_bd=0, pushed word lost.
- With DECODE_QUEUE_STALL_ON_EXC_EN: pop a SYSCALL with a nop behind it -> id_valid=0 until flush. Without the macro, the nop is presented the next cycle.

Source files
------------

// File: rtl/decode_queue_if.sv
// ---------------------------------------------------------------------------
// decode_queue_if
// Handshake bundle between instruction fetch, the decode queue and decode.
//
// Fetch side : if_valid, if_ready, if_pc, if_inst, if_fetch_err
// Decode side: id_valid, id_ready, id_pc, id_inst, id_bd, id_is_branch,
//              id_is_eret, id_exc, id_excode
// Status     : occupancy (number of buffered instructions)
//
// Modports:
//   slave  - the queue itself (accepts fetches, presents the head to decode)
//   master - the surrounding pipeline (drives fetches, consumes the head)
// ---------------------------------------------------------------------------
interface decode_queue_if #(
   parameter int PTR_W = 2,
   parameter int PC_W  = 32
);
   logic              if_valid;
   logic              if_ready;
   logic [PC_W-1:0]   if_pc;
   logic [31:0]       if_inst;
   logic              if_fetch_err;

   logic              id_valid;
   logic              id_ready;
   logic [PC_W-1:0]   id_pc;
   logic [31:0]       id_inst;
   logic              id_bd;
   logic              id_is_branch;
   logic              id_is_eret;
   logic              id_exc;
   logic [4:0]        id_excode;

   logic [PTR_W:0]    occupancy;

   modport slave (
      input  if_valid, if_pc, if_inst, if_fetch_err, id_ready,
      output if_ready, id_valid, id_pc, id_inst, id_bd, id_is_branch,
             id_is_eret, id_exc, id_excode, occupancy
   );

   modport master (
      output if_valid, if_pc, if_inst, if_fetch_err, id_ready,
      input  if_ready, id_valid, id_pc, id_inst, id_bd, id_is_branch,
             id_is_eret, id_exc, id_excode, occupancy
   );
endinterface

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
// Instruction buffer and pre-decode stage sitting between IF and ID of the
// MIPS pipeline. Fetched instructions are held in a circular FIFO of
// 2^PTR_W entries; the head entry is classified (branch/jump, ERET,
// SYSCALL, BREAK, reserved instruction) and tagged with its branch delay
// slot status and a prioritised exception code.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset
//   flush  - synchronous pipeline flush, empties the queue
//   q      - decode_queue_if.slave bundle (fetch side, decode side,
//            occupancy)
//
// Build option:
//   DECODE_QUEUE_STALL_ON_EXC_EN - when defined, popping an instruction
//   that carries an exception freezes the decode side until a flush or
//   reset. When undefined, following entries are presented normally.
// ---------------------------------------------------------------------------
module decode_queue #(
   parameter int PTR_W = 2,
   parameter int PC_W  = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   decode_queue_if.slave  q
);

   localparam int             DEPTH      = 1 << PTR_W;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;

   logic [PC_W-1:0]  pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic             err_mem  [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             bd_flag;
   logic             stall_flag;

   logic             ready_int;
   logic             valid_int;
   logic             push;
   logic             pop;

   logic [PC_W-1:0]  head_pc;
   logic [31:0]      head_inst;
   logic             head_err;
   logic [5:0]       opcode;
   logic [4:0]       rt;
   logic [5:0]       funct;
   logic             is_branch;
   logic             is_eret;
   logic             op_legal;
   logic             is_syscall;
   logic             is_break;
   logic             exc;
   logic [4:0]       excode;

   // A full queue refuses pushes even if the head is popped in the same
   // cycle, so if_ready never depends combinationally on id_ready.
   assign ready_int = (count != FULL_COUNT);
   assign valid_int = (count != '0) && !stall_flag;

   // Flush wins over both handshakes: nothing is written and nothing is
   // consumed in the flush cycle.
   assign push = q.if_valid && ready_int && !flush;
   assign pop  = valid_int && q.id_ready && !flush;

   assign head_pc   = pc_mem[rd_ptr];
   assign head_inst = inst_mem[rd_ptr];
   assign head_err  = err_mem[rd_ptr];
   assign opcode    = head_inst[31:26];
   assign rt        = head_inst[20:16];
   assign funct     = head_inst[5:0];

   // Pre-decode of the head entry. REGIMM branches are the rt values whose
   // middle three bits are zero (bltz/bgez and their linking forms); jr and
   // jalr share funct 00100x.
   always_comb begin
      is_branch = 1'b0;
      case (opcode)
         6'b000010, 6'b000011, 6'b000100,
         6'b000101, 6'b000110, 6'b000111: is_branch = 1'b1;
         6'b000001:                       is_branch = (rt[3:1] == 3'b000);
         6'b000000:                       is_branch = (funct[5:1] == 5'b00100);
         default:                         is_branch = 1'b0;
      endcase

      op_legal = 1'b0;
      if (opcode[5:4] == 2'b00)
         op_legal = 1'b1;
      else if (opcode == 6'b010000)
         op_legal = 1'b1;
      else if (opcode[5:3] == 3'b100 && opcode[2:0] != 3'b111)
         op_legal = 1'b1;
      else if (opcode[5:2] == 4'b1010)
         op_legal = 1'b1;
      else if (opcode == 6'b101110)
         op_legal = 1'b1;

      is_eret    = (head_inst == 32'h4200_0018);
      is_syscall = (opcode == 6'b000000) && (funct == 6'b001100);
      is_break   = (opcode == 6'b000000) && (funct == 6'b001101);

      // A fetch address error means the word itself is meaningless, so it
      // outranks anything decoded from it.
      exc    = 1'b1;
      excode = EXC_ADEL;
      if (head_err)
         excode = EXC_ADEL;
      else if (!op_legal)
         excode = EXC_RI;
      else if (is_syscall)
         excode = EXC_SYS;
      else if (is_break)
         excode = EXC_BP;
      else begin
         exc    = 1'b0;
         excode = 5'd0;
      end
   end

   // Everything on the decode side reads zero while no entry is presented,
   // which also keeps the unreset storage from leaking out after reset.
   assign q.if_ready     = ready_int;
   assign q.id_valid     = valid_int;
   assign q.id_pc        = valid_int ? head_pc   : '0;
   assign q.id_inst      = valid_int ? head_inst : '0;
   assign q.id_bd        = valid_int && bd_flag;
   assign q.id_is_branch = valid_int && is_branch;
   assign q.id_is_eret   = valid_int && is_eret;
   assign q.id_exc       = valid_int && exc;
   assign q.id_excode    = valid_int ? excode : 5'd0;
   assign q.occupancy    = count;

   // Storage is deliberately left without reset; the pointers and count
   // decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= q.if_pc;
         inst_mem[wr_ptr] <= q.if_inst;
         err_mem[wr_ptr]  <= q.if_fetch_err;
      end
   end

   // Queue control. The delay-slot flag remembers whether the last popped
   // instruction was a branch, so it follows the instruction stream rather
   // than the storage slots.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         bd_flag    <= 1'b0;
         stall_flag <= 1'b0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         bd_flag    <= 1'b0;
         stall_flag <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            bd_flag <= is_branch;
         end
`ifdef DECODE_QUEUE_STALL_ON_EXC_EN
         if (pop && exc)
            stall_flag <= 1'b1;
`else
         stall_flag <= 1'b0;
`endif
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
